// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock core.
// Optional hourly chime is enabled with the ALARM_CLOCK_HOURLY_CHIME_EN macro.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_TIME_HM  = 3'd1;
    localparam logic [2:0] ADDR_TIME_S   = 3'd2;
    localparam logic [2:0] ADDR_ALARM_HM = 3'd3;
    localparam logic [2:0] ADDR_CONTROL  = 3'd4;

    localparam int CTRL_ALARM_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_SNOOZE   = 2;
    localparam int CTRL_CHIME_EN = 3;

    localparam int DATA_W = 16;
    localparam int BCD_W  = 8;
    localparam int TIME_W = 24;

    // HH:MM word is accepted only if every nibble is a decimal digit and HH<=23, MM<=59.
    function automatic logic hm_valid(input logic [DATA_W-1:0] d);
        return (d[15:12] <= 4'd2) && (d[11:8] <= 4'd9) && (d[15:8] <= 8'h23) &&
               (d[7:4] <= 4'd5) && (d[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter that wraps at MAX and flags a carry on the wrapping increment.
module bcd_digit_counter
    import alarm_clock_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX       = 8'h59,
    parameter logic [BCD_W-1:0] RESET_VAL = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_value,
    output logic [BCD_W-1:0] value,
    output logic             carry
);

    assign carry = inc && (value == MAX);

    // Load has priority over increment; the units digit rolls into the tens digit at 9.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= RESET_VAL;
        end else if (load) begin
            value <= load_value;
        end else if (inc) begin
            if (value == MAX)
                value <= '0;
            else if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'd0};
            else
                value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/alarm_clock_core.sv
// Alarm clock core: BCD time of day from a 1 Hz tick level, alarm compare,
// ring/snooze FSM and a 16-bit register slave.
// Define ALARM_CLOCK_HOURLY_CHIME_EN to add the hourly chime output and CONTROL[3].
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int              RING_SECONDS   = 60,
    parameter int              SNOOZE_SECONDS = 300,
    parameter logic [TIME_W-1:0] RESET_TIME   = 24'h120000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_in,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic              alarm_out,
    output logic [TIME_W-1:0] time_bcd
`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
    ,
    output logic              chime
`endif
);

    localparam logic [7:0]  RING_LAST   = 8'(RING_SECONDS - 1);
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_SECONDS);

    state_t             state;
    logic [7:0]         ring_cnt;
    logic [15:0]        snooze_cnt;
    logic [DATA_W-1:0]  alarm_hm;
    logic               alarm_en, irq_en, chime_en;
    logic               tick_d, tick_q;
    logic [BCD_W-1:0]   hh, mm, ss;
    logic               carry_s, carry_m, carry_h;

    // Bus decode
    logic wr, rd, wr_time, wr_alarm, wr_ctrl, dismiss, disable_req, snooze_req;
    assign wr          = chipselect && !write_n;
    assign rd          = chipselect && write_n;
    assign wr_time     = wr && (address == ADDR_TIME_HM) && hm_valid(writedata);
    assign wr_alarm    = wr && (address == ADDR_ALARM_HM) && hm_valid(writedata);
    assign wr_ctrl     = wr && (address == ADDR_CONTROL);
    assign dismiss     = wr && (address == ADDR_STATUS);
    assign disable_req = wr_ctrl && !writedata[CTRL_ALARM_EN];
    assign snooze_req  = wr_ctrl && writedata[CTRL_SNOOZE];

    // A time write in the same cycle as a tick swallows that tick.
    logic tick, tick_eff;
    assign tick     = tick_in && !tick_d;
    assign tick_eff = tick && !wr_time;

    // tick_q marks the cycle in which the time registers hold a freshly ticked value.
    logic alarm_hit;
    assign alarm_hit = tick_q && alarm_en && (hh == alarm_hm[15:8]) &&
                       (mm == alarm_hm[7:0]) && (ss == 8'h00);

    bcd_digit_counter #(.MAX(8'h59), .RESET_VAL(RESET_TIME[7:0])) u_ss (
        .clk(clk), .reset(reset), .inc(tick_eff), .load(wr_time),
        .load_value(8'h00), .value(ss), .carry(carry_s));

    bcd_digit_counter #(.MAX(8'h59), .RESET_VAL(RESET_TIME[15:8])) u_mm (
        .clk(clk), .reset(reset), .inc(carry_s), .load(wr_time),
        .load_value(writedata[7:0]), .value(mm), .carry(carry_m));

    bcd_digit_counter #(.MAX(8'h23), .RESET_VAL(RESET_TIME[23:16])) u_hh (
        .clk(clk), .reset(reset), .inc(carry_m), .load(wr_time),
        .load_value(writedata[15:8]), .value(hh), .carry(carry_h));

    // Midnight wrap needs no action beyond the hour counter itself.
    logic unused_carry;
    assign unused_carry = carry_h;

    assign time_bcd = {hh, mm, ss};
    assign irq      = alarm_out && irq_en;

    // Tick edge history and the alarm / control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_d   <= 1'b0;
            tick_q   <= 1'b0;
            alarm_hm <= '0;
            alarm_en <= 1'b0;
            irq_en   <= 1'b0;
            chime_en <= 1'b0;
        end else begin
            tick_d <= tick_in;
            tick_q <= tick_eff;
            if (wr_alarm)
                alarm_hm <= writedata;
            if (wr_ctrl) begin
                alarm_en <= writedata[CTRL_ALARM_EN];
                irq_en   <= writedata[CTRL_IRQ_EN];
`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
                chime_en <= writedata[CTRL_CHIME_EN];
`endif
            end
        end
    end

    // Ring/snooze FSM; dismiss/disable beat the snooze strobe, which beats tick events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            alarm_out  <= 1'b0;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else if (dismiss || disable_req) begin
            state     <= ST_IDLE;
            alarm_out <= 1'b0;
        end else if (snooze_req && state == ST_RING) begin
            state      <= ST_SNOOZE;
            alarm_out  <= 1'b0;
            snooze_cnt <= SNOOZE_LOAD;
        end else begin
            case (state)
                ST_IDLE: if (alarm_hit) begin
                    state     <= ST_RING;
                    alarm_out <= 1'b1;
                    ring_cnt  <= '0;
                end
                ST_RING: if (tick) begin
                    ring_cnt <= ring_cnt + 8'd1;
                    if (ring_cnt == RING_LAST) begin
                        state     <= ST_IDLE;
                        alarm_out <= 1'b0;
                    end
                end
                ST_SNOOZE: if (tick) begin
                    snooze_cnt <= snooze_cnt - 16'd1;
                    if (snooze_cnt == 16'd1) begin
                        state     <= ST_RING;
                        alarm_out <= 1'b1;
                        ring_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    alarm_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
    // One-cycle pulse when a tick lands on the top of the hour.
    always_ff @(posedge clk) begin
        if (reset)
            chime <= 1'b0;
        else
            chime <= chime_en && tick_q && (mm == 8'h00) && (ss == 8'h00);
    end
`endif

    // Registered read mux; unmapped addresses return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd) begin
            case (address)
                ADDR_STATUS:   readdata <= {14'b0, state == ST_SNOOZE, state == ST_RING};
                ADDR_TIME_HM:  readdata <= {hh, mm};
                ADDR_TIME_S:   readdata <= {8'h00, ss};
                ADDR_ALARM_HM: readdata <= alarm_hm;
                ADDR_CONTROL:  readdata <= {12'b0, chime_en, 1'b0, irq_en, alarm_en};
                default:       readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Scoreboard bench for alarm_clock_core: stimulus pushes expectations, a
// negedge monitor pops and compares reads and sampled outputs.
module tb_alarm_clock_core;

    localparam int RING_S   = 5;
    localparam int SNOOZE_S = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_in = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq, alarm_out;
    logic [23:0] time_bcd;
`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
    logic        chime;
`endif

    always #5 clk = ~clk;

    alarm_clock_core #(
        .RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNOOZE_S), .RESET_TIME(24'h120000)
    ) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq), .alarm_out(alarm_out), .time_bcd(time_bcd)
`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
        , .chime(chime)
`endif
    );

    typedef struct {
        string       name;
        int          kind;   // 0 readdata, 1 time_bcd, 2 irq, 3 alarm_out, 4 chime count
        logic [31:0] exp;
    } item_t;

    item_t rd_q[$];
    item_t sig_q[$];
    int    checks = 0;
    int    failures = 0;
    int    chime_cnt = 0;
    logic  rd_vld = 1'b0;

    always @(posedge clk) rd_vld <= chipselect & write_n;

`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
    always @(posedge clk) if (chime) chime_cnt <= chime_cnt + 1;
`endif

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0:       return {16'b0, readdata};
            1:       return {8'b0, time_bcd};
            2:       return {31'b0, irq};
            3:       return {31'b0, alarm_out};
            default: return 32'(chime_cnt);
        endcase
    endfunction

    task automatic compare(input item_t it);
        logic [31:0] a;
        a = actual(it.kind);
        checks++;
        if (a !== it.exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", it.name, a, it.exp);
        end
    endtask

    // Monitor: a read result is valid the cycle after the read strobe.
    always @(negedge clk) begin
        item_t it;
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read got=%h exp=none", readdata);
            end else begin
                it = rd_q.pop_front();
                compare(it);
            end
        end
        while (sig_q.size() > 0) begin
            it = sig_q.pop_front();
            compare(it);
        end
    end

    task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
        rd_q.push_back('{n, 0, {16'b0, e}});
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk(input int kind, input logic [31:0] e, input string n);
        sig_q.push_back('{n, kind, e});
        @(posedge clk); #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            repeat (3) @(posedge clk);
            #1 tick_in = 1'b0;
            repeat (2) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk(1, 32'h120000, "reset_time_bcd");
        chk(2, 0, "reset_irq");
        chk(3, 0, "reset_alarm_out");
        rd(3'd1, 16'h1200, "reset_time_hm");
        rd(3'd2, 16'h0000, "reset_time_s");
        rd(3'd4, 16'h0000, "reset_control");
        rd(3'd0, 16'h0000, "reset_status");
        rd(3'd5, 16'h0000, "unmapped_read");

        // Midnight rollover; tick_in held high several cycles per second
        wr(3'd1, 16'h2359);
        rd(3'd1, 16'h2359, "time_hm_write");
        tick(1);
        chk(1, 32'h235901, "single_tick");
        tick(59);
        chk(1, 32'h000000, "midnight_wrap");
        rd(3'd2, 16'h0000, "midnight_ss");

        // Alarm fires and rings for RING_S seconds
        wr(3'd3, 16'h0701);
        wr(3'd4, 16'h0003);
        wr(3'd1, 16'h0700);
        rd(3'd3, 16'h0701, "alarm_hm_write");
        rd(3'd4, 16'h0003, "control_write");
        tick(59);
        rd(3'd0, 16'h0000, "pre_alarm_idle");
        tick(1);
        chk(1, 32'h070100, "alarm_time");
        chk(2, 1, "ring_irq");
        chk(3, 1, "ring_alarm_out");
        rd(3'd0, 16'h0001, "ring_status");
        tick(RING_S - 1);
        rd(3'd0, 16'h0001, "ring_before_timeout");
        tick(1);
        rd(3'd0, 16'h0000, "ring_timeout");
        chk(2, 0, "timeout_irq");
        chk(3, 0, "timeout_alarm_out");

        // Snooze, re-ring, dismiss
        wr(3'd1, 16'h0700);
        tick(60);
        rd(3'd0, 16'h0001, "ring2_status");
        wr(3'd4, 16'h0007);
        rd(3'd0, 16'h0002, "snooze_status");
        chk(3, 0, "snooze_alarm_out");
        chk(2, 0, "snooze_irq");
        rd(3'd4, 16'h0003, "snooze_bit_not_stored");
        tick(SNOOZE_S - 1);
        rd(3'd0, 16'h0002, "snooze_before_end");
        tick(1);
        rd(3'd0, 16'h0001, "snooze_rering");
        chk(2, 1, "rering_irq");
        wr(3'd0, 16'h0000);
        rd(3'd0, 16'h0000, "dismiss_status");
        chk(3, 0, "dismiss_alarm_out");

        // Snooze strobe together with disable: disable wins
        wr(3'd1, 16'h0700);
        tick(60);
        rd(3'd0, 16'h0001, "ring3_status");
        wr(3'd4, 16'h0006);
        rd(3'd0, 16'h0000, "snooze_disable_status");
        rd(3'd4, 16'h0002, "snooze_disable_control");
        wr(3'd4, 16'h0007);
        rd(3'd0, 16'h0000, "idle_snooze_ignored");
        rd(3'd4, 16'h0003, "idle_snooze_control");

        // Invalid BCD writes are dropped
        wr(3'd1, 16'h1234);
        rd(3'd1, 16'h1234, "valid_time_write");
        wr(3'd1, 16'h2460);
        rd(3'd1, 16'h1234, "invalid_2460");
        wr(3'd1, 16'h1A00);
        rd(3'd1, 16'h1234, "invalid_1a00");
        wr(3'd3, 16'h0760);
        rd(3'd3, 16'h0701, "invalid_alarm");
        tick(3);
        chk(1, 32'h123403, "ticks_after_write");

        // Time write coincident with a tick edge: write wins, tick dropped
        tick_in = 1'b1;
        wr(3'd1, 16'h0815);
        repeat (2) @(posedge clk);
        #1 tick_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk(1, 32'h081500, "write_beats_tick");
        rd(3'd2, 16'h0000, "write_beats_tick_ss");

`ifdef ALARM_CLOCK_HOURLY_CHIME_EN
        wr(3'd4, 16'h000B);
        rd(3'd4, 16'h000B, "chime_control");
        wr(3'd1, 16'h1059);
        tick(59);
        chk(4, 0, "chime_before_hour");
        tick(1);
        chk(1, 32'h110000, "chime_hour_time");
        chk(4, 1, "chime_one_pulse");
        wr(3'd4, 16'h0003);
        wr(3'd1, 16'h1159);
        tick(60);
        chk(4, 1, "chime_disabled");
`else
        wr(3'd4, 16'h000B);
        rd(3'd4, 16'h0003, "control_bit3_ignored");
        wr(3'd4, 16'h0003);
`endif

        for (int i = 0; i < 20 && (rd_q.size() != 0 || sig_q.size() != 0); i++)
            @(posedge clk);
        if (rd_q.size() != 0 || sig_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d exp=0", rd_q.size() + sig_q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
